// File: rtl/approx_mul_pkg.sv
// Shared widths, beat tag and helpers for the approximate multiply-accumulate scheduler.
package approx_mul_pkg;

    localparam int unsigned OPERAND_W = 8;
    localparam int unsigned PRODUCT_W = 16;
    localparam int unsigned MIN_ACC_W = PRODUCT_W;
    localparam int unsigned MAX_REQ   = 8;
    localparam int unsigned TAG_ID_W  = 3;

    typedef struct packed {
        logic [TAG_ID_W-1:0] id;
        logic                first;
        logic                last;
    } beat_tag_t;

    // Accumulator must hold at least one full product.
    function automatic bit acc_w_ok(input int unsigned w);
        return w >= MIN_ACC_W;
    endfunction

    // 3:2 carry-save compressor over full product-width rows.
    function automatic void csa(
        input  logic [PRODUCT_W-1:0] x,
        input  logic [PRODUCT_W-1:0] y,
        input  logic [PRODUCT_W-1:0] z,
        output logic [PRODUCT_W-1:0] s,
        output logic [PRODUCT_W-1:0] c
    );
        s = x ^ y ^ z;
        c = ((x & y) | (x & z) | (y & z)) << 1;
    endfunction

endpackage

// File: rtl/approx_eight_bit_wallace_tree.sv
// Approximate 8x8 unsigned multiplier: partial-product bits in the two lowest
// columns are discarded, the remaining rows are reduced by a carry-save tree.
module approx_eight_bit_wallace_tree
    import approx_mul_pkg::*;
(
    input  logic [OPERAND_W-1:0] a,
    input  logic [OPERAND_W-1:0] b,
    output logic [PRODUCT_W-1:0] product_c
);

    localparam int unsigned DROP_COLS = 2;

    logic [PRODUCT_W-1:0] pp [OPERAND_W];
    logic [PRODUCT_W-1:0] l1 [6];
    logic [PRODUCT_W-1:0] l2 [4];
    logic [PRODUCT_W-1:0] l3 [3];
    logic [PRODUCT_W-1:0] l4 [2];

    always_comb begin
        for (int unsigned i = 0; i < OPERAND_W; i++) begin
            pp[i] = b[i] ? (PRODUCT_W'(a) << i) : '0;
            pp[i][DROP_COLS-1:0] = '0;
        end
        // 8 -> 6 -> 4 -> 3 -> 2 rows, then one carry-propagate add.
        csa(pp[0], pp[1], pp[2], l1[0], l1[1]);
        csa(pp[3], pp[4], pp[5], l1[2], l1[3]);
        l1[4] = pp[6];
        l1[5] = pp[7];
        csa(l1[0], l1[1], l1[2], l2[0], l2[1]);
        csa(l1[3], l1[4], l1[5], l2[2], l2[3]);
        csa(l2[0], l2[1], l2[2], l3[0], l3[1]);
        l3[2] = l2[3];
        csa(l3[0], l3[1], l3[2], l4[0], l4[1]);
        product_c = l4[0] + l4[1];
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched upward from the pointer with wrap;
// the pointer moves past the granted requester only when the grant is taken.
module rr_arbiter #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] valid,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant_c,
    output logic [ID_W-1:0]    grant_id_c
);

    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] ptr_d;
    logic            found;
    int unsigned     idx;

    always_comb begin
        grant_c    = '0;
        grant_id_c = '0;
        found      = 1'b0;
        idx        = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && valid[ID_W'(idx)]) begin
                found                = 1'b1;
                grant_c[ID_W'(idx)]  = 1'b1;
                grant_id_c           = ID_W'(idx);
            end
        end
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = (32'(grant_id_c) == NUM_REQ - 1) ? '0 : grant_id_c + ID_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/approx_mul_scheduler.sv
// Shares one approximate multiplier among NUM_REQ accumulating requesters.
// Define EXACT_ERR_EN to also track the accumulated (exact - approx) error.
module approx_mul_scheduler
    import approx_mul_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    parameter  int unsigned ACC_W   = 20,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*OPERAND_W-1:0] req_a,
    input  logic [NUM_REQ*OPERAND_W-1:0] req_b,
    input  logic [NUM_REQ-1:0]           req_first,
    input  logic [NUM_REQ-1:0]           req_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ID_W-1:0]              out_id,
    output logic [ACC_W-1:0]             out_acc,
    output logic [ACC_W-1:0]             out_err,
    output logic                         busy
);

    if (!acc_w_ok(ACC_W) || NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_param_check
        $error("approx_mul_scheduler: illegal NUM_REQ/ACC_W");
    end

    logic                 stall;
    logic                 handshake;
    logic [NUM_REQ-1:0]   grant_c;
    logic [ID_W-1:0]      grant_id_c;
    logic [OPERAND_W-1:0] sel_a;
    logic [OPERAND_W-1:0] sel_b;
    logic                 sel_first;
    logic                 sel_last;
    logic [PRODUCT_W-1:0] tree_p;

    logic                 s1_v_q, s1_v_d;
    logic [OPERAND_W-1:0] s1_a_q, s1_a_d;
    logic [OPERAND_W-1:0] s1_b_q, s1_b_d;
    beat_tag_t            s1_tag_q, s1_tag_d;

    logic                 s2_v_q, s2_v_d;
    logic [PRODUCT_W-1:0] s2_p_q, s2_p_d;
    beat_tag_t            s2_tag_q, s2_tag_d;

    logic [ACC_W-1:0]     acc_q [NUM_REQ];
    logic [ACC_W-1:0]     acc_d [NUM_REQ];
    logic [ID_W-1:0]      s3_id;
    logic [ACC_W-1:0]     s3_sum;
    logic                 tag_id_unused;

    logic                 out_valid_q, out_valid_d;
    logic [ID_W-1:0]      out_id_q, out_id_d;
    logic [ACC_W-1:0]     out_acc_q, out_acc_d;

`ifdef EXACT_ERR_EN
    logic [PRODUCT_W-1:0] s2_exact_q, s2_exact_d;
    logic [ACC_W-1:0]     err_q [NUM_REQ];
    logic [ACC_W-1:0]     err_d [NUM_REQ];
    logic [ACC_W-1:0]     s3_err;
    logic [ACC_W-1:0]     out_err_q, out_err_d;
`endif

    assign stall     = out_valid_q & ~out_ready;
    assign req_ready = stall ? '0 : grant_c;
    assign handshake = |req_ready;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk        (clk),
        .rst        (rst),
        .valid      (req_valid),
        .advance    (handshake),
        .grant_c    (grant_c),
        .grant_id_c (grant_id_c)
    );

    approx_eight_bit_wallace_tree u_mul (
        .a         (s1_a_q),
        .b         (s1_b_q),
        .product_c (tree_p)
    );

    // Operand mux driven by the one-hot grant.
    always_comb begin
        sel_a     = '0;
        sel_b     = '0;
        sel_first = 1'b0;
        sel_last  = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_c[i]) begin
                sel_a     = req_a[i*OPERAND_W +: OPERAND_W];
                sel_b     = req_b[i*OPERAND_W +: OPERAND_W];
                sel_first = req_first[i];
                sel_last  = req_last[i];
            end
        end
    end

    // Whole pipeline advances together; a blocked result freezes every stage.
    always_comb begin
        s1_v_d      = s1_v_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_tag_d    = s1_tag_q;
        s2_v_d      = s2_v_q;
        s2_p_d      = s2_p_q;
        s2_tag_d    = s2_tag_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_id_d    = out_id_q;
        out_acc_d   = out_acc_q;
        s3_id       = ID_W'(s2_tag_q.id);
        s3_sum      = (s2_tag_q.first ? '0 : acc_q[s3_id]) + ACC_W'(s2_p_q);
`ifdef EXACT_ERR_EN
        s2_exact_d  = s2_exact_q;
        err_d       = err_q;
        out_err_d   = out_err_q;
        s3_err      = (s2_tag_q.first ? '0 : err_q[s3_id])
                      + ACC_W'(s2_exact_q) - ACC_W'(s2_p_q);
`endif
        if (!stall) begin
            s1_v_d = handshake;
            if (handshake) begin
                s1_a_d         = sel_a;
                s1_b_d         = sel_b;
                s1_tag_d.id    = TAG_ID_W'(grant_id_c);
                s1_tag_d.first = sel_first;
                s1_tag_d.last  = sel_last;
            end
            s2_v_d   = s1_v_q;
            s2_p_d   = tree_p;
            s2_tag_d = s1_tag_q;
`ifdef EXACT_ERR_EN
            s2_exact_d = PRODUCT_W'(s1_a_q) * PRODUCT_W'(s1_b_q);
`endif
            if (s2_v_q) begin
                acc_d[s3_id] = s3_sum;
`ifdef EXACT_ERR_EN
                err_d[s3_id] = s3_err;
`endif
            end
            out_valid_d = s2_v_q & s2_tag_q.last;
            if (s2_v_q && s2_tag_q.last) begin
                out_id_d  = s3_id;
                out_acc_d = s3_sum;
`ifdef EXACT_ERR_EN
                out_err_d = s3_err;
`endif
            end
        end
    end

    assign tag_id_unused = ^s2_tag_q.id;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q      <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_tag_q    <= '0;
            s2_v_q      <= 1'b0;
            s2_p_q      <= '0;
            s2_tag_q    <= '0;
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_acc_q   <= '0;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            s1_v_q      <= s1_v_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_tag_q    <= s1_tag_d;
            s2_v_q      <= s2_v_d;
            s2_p_q      <= s2_p_d;
            s2_tag_q    <= s2_tag_d;
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            out_acc_q   <= out_acc_d;
            acc_q       <= acc_d;
        end
    end

`ifdef EXACT_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_exact_q <= '0;
            out_err_q  <= '0;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                err_q[i] <= '0;
            end
        end else begin
            s2_exact_q <= s2_exact_d;
            out_err_q  <= out_err_d;
            err_q      <= err_d;
        end
    end

    assign out_err = out_err_q;
`else
    assign out_err = '0;
`endif

    assign out_valid = out_valid_q;
    assign out_id    = out_id_q;
    assign out_acc   = out_acc_q;
    assign busy      = s1_v_q | s2_v_q | out_valid_q;

endmodule

// File: tb/tb_approx_mul_scheduler.sv
// Self-checking bench for approx_mul_scheduler: directed scenarios followed by
// random traffic, compared against a transaction-level reference model.
module tb_approx_mul_scheduler;

    localparam int NREQ = 4;
    localparam int AW   = 20;
    localparam int IW   = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req_valid, req_ready, req_first, req_last;
    logic [NREQ*8-1:0] req_a, req_b;
    logic            out_valid, out_ready, busy;
    logic [IW-1:0]   out_id;
    logic [AW-1:0]   out_acc, out_err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int            m_ptr;
    logic [AW-1:0] m_acc [NREQ];
    logic [AW-1:0] m_err [NREQ];
    bit            m1_v, m1_last, m2_v, m2_last, m_ov;
    int            m1_id, m2_id, m_oid;
    logic [AW-1:0] m1_acc, m1_err, m2_acc, m2_err, m_oacc, m_oerr;

    // Results actually accepted from the DUT
    int            dut_res_cnt = 0;
    logic [AW-1:0] dut_res_acc [NREQ];

    always #5 clk = ~clk;

    approx_mul_scheduler #(.NUM_REQ(NREQ), .ACC_W(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .req_first(req_first), .req_last(req_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_id(out_id), .out_acc(out_acc), .out_err(out_err),
        .busy(busy)
    );

    // Approximate product: exact product minus the partial-product bits of weight 1 and 2.
    function automatic int tree_model(input int a, input int b);
        int drop;
        drop = (a & b & 1)
             + 2 * (((a & 1) & ((b >> 1) & 1)) + (((a >> 1) & 1) & (b & 1)));
        return a * b - drop;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0;
        m1_v = 0; m2_v = 0; m_ov = 0;
        m1_last = 0; m2_last = 0;
        m1_id = 0; m2_id = 0; m_oid = 0;
        m1_acc = '0; m1_err = '0; m2_acc = '0; m2_err = '0;
        m_oacc = '0; m_oerr = '0;
        for (int i = 0; i < NREQ; i++) begin
            m_acc[i] = '0;
            m_err[i] = '0;
        end
    endtask

    task automatic drive_idle();
        req_valid = '0; req_first = '0; req_last = '0;
        req_a = '0; req_b = '0;
    endtask

    task automatic drive_req(input int i, input int a, input int b, input bit f, input bit l);
        req_valid[i] = 1'b1;
        req_a[8*i +: 8] = 8'(a);
        req_b[8*i +: 8] = 8'(b);
        req_first[i] = f;
        req_last[i] = l;
    endtask

    // One clock: check grant before the edge, advance the model at the edge, check outputs after.
    task automatic step();
        int g, idx, a, b, p;
        bit m_stall;
        logic [NREQ-1:0] exp_rdy;
        logic [AW-1:0] exp_err;
        @(negedge clk);
        m_stall = m_ov && !out_ready;
        g = -1;
        if (!m_stall) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        exp_rdy = (g >= 0) ? NREQ'(1 << g) : '0;
        if (!rst) begin
            check("req_ready", 32'(req_ready), 32'(exp_rdy));
            if (out_valid && out_ready) begin
                dut_res_cnt++;
                dut_res_acc[out_id] = out_acc;
            end
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (!m_stall) begin
            if (m2_v && m2_last) begin
                m_ov = 1; m_oid = m2_id; m_oacc = m2_acc; m_oerr = m2_err;
            end else begin
                m_ov = 0;
            end
            m2_v = m1_v; m2_last = m1_last; m2_id = m1_id; m2_acc = m1_acc; m2_err = m1_err;
            if (g >= 0) begin
                a = int'(req_a[8*g +: 8]);
                b = int'(req_b[8*g +: 8]);
                p = tree_model(a, b);
                m_acc[g] = (req_first[g] ? '0 : m_acc[g]) + AW'(p);
                m_err[g] = (req_first[g] ? '0 : m_err[g]) + AW'(a * b - p);
                m1_v = 1; m1_last = req_last[g]; m1_id = g;
                m1_acc = m_acc[g]; m1_err = m_err[g];
                m_ptr = (g + 1) % NREQ;
            end else begin
                m1_v = 0;
            end
        end
        #1;
`ifdef EXACT_ERR_EN
        exp_err = m_oerr;
`else
        exp_err = '0;
`endif
        check("out_valid", 32'(out_valid), 32'(m_ov));
        check("out_id",    32'(out_id),    32'(m_oid));
        check("out_acc",   32'(out_acc),   32'(m_oacc));
        check("out_err",   32'(out_err),   32'(exp_err));
        check("busy",      32'(busy),      32'(m1_v | m2_v | m_ov));
    endtask

    initial begin
        int cnt0;
        logic [AW-1:0] held_acc;
        logic [IW-1:0] held_id;
        rst = 1'b1;
        out_ready = 1'b1;
        drive_idle();
        model_reset();
        for (int i = 0; i < NREQ; i++) dut_res_acc[i] = '0;
        step();
        step();
        rst = 1'b0;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_acc", 32'(out_acc), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);

        // T1: single first+last beat, latency 3
        drive_req(0, 3, 5, 1'b1, 1'b1);
        step();
        drive_idle();
        step();
        check("t1_not_yet", 32'(out_valid), 32'd0);
        step();
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_id", 32'(out_id), 32'd0);
        check("t1_acc", 32'(out_acc), 32'(tree_model(3, 5)));
        step();

        // T2: four-beat sum on requester 1
        cnt0 = dut_res_cnt;
        for (int k = 0; k < 4; k++) begin
            drive_idle();
            drive_req(1, 8'h10, 8'h10, k == 0, k == 3);
            step();
        end
        drive_idle();
        for (int k = 0; k < 4; k++) step();
        check("t2_count", 32'(dut_res_cnt - cnt0), 32'd1);
        check("t2_acc", 32'(dut_res_acc[1]), 32'(4 * tree_model(16, 16)));

        // T3: all requesters valid after reset, round-robin from 0
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            drive_idle();
            for (int i = 0; i < NREQ; i++) drive_req(i, $urandom_range(255), $urandom_range(255), 1'b1, 1'b1);
            #1;
            check("t3_grant", 32'(req_ready), 32'(1 << (k % NREQ)));
            step();
        end

        // T4: output blocked for 5 cycles with requesters still valid
        cnt0 = dut_res_cnt;
        out_ready = 1'b0;
        held_acc = out_acc;
        held_id = out_id;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("t4_ready_zero", 32'(req_ready), 32'd0);
            step();
            check("t4_hold_valid", 32'(out_valid), 32'd1);
            check("t4_hold_acc", 32'(out_acc), 32'(held_acc));
            check("t4_hold_id", 32'(out_id), 32'(held_id));
        end
        out_ready = 1'b1;
        drive_idle();
        for (int k = 0; k < 6; k++) step();
        check("t4_count", 32'(dut_res_cnt - cnt0), 32'd3);

        // T5: 17 beats of 0xFF*0xFF wrap the accumulator
        cnt0 = dut_res_cnt;
        for (int k = 0; k < 17; k++) begin
            drive_idle();
            drive_req(2, 8'hFF, 8'hFF, k == 0, k == 16);
            step();
        end
        drive_idle();
        for (int k = 0; k < 4; k++) step();
        check("t5_count", 32'(dut_res_cnt - cnt0), 32'd1);
        check("t5_acc", 32'(dut_res_acc[2]), 32'((17 * tree_model(255, 255)) % (1 << AW)));

        // T6: reset with a full pipeline and a pending result
        for (int k = 0; k < 3; k++) begin
            drive_idle();
            for (int i = 0; i < NREQ; i++) drive_req(i, k + 1, i + 1, 1'b1, 1'b1);
            step();
        end
        check("t6_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_out_valid", 32'(out_valid), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        #1;
        check("t6_ptr_zero", 32'(req_ready), 32'd1);
        drive_idle();
        drive_req(3, 2, 2, 1'b0, 1'b1);
        cnt0 = dut_res_cnt;
        step();
        drive_idle();
        for (int k = 0; k < 4; k++) step();
        check("t6_count", 32'(dut_res_cnt - cnt0), 32'd1);
        check("t6_acc", 32'(dut_res_acc[3]), 32'(tree_model(2, 2)));

        // Random traffic with occasional back-pressure and reset
        for (int c = 0; c < 300; c++) begin
            rst = ($urandom_range(63) == 0);
            out_ready = ($urandom_range(3) != 0);
            req_valid = NREQ'($urandom);
            req_a = $urandom;
            req_b = $urandom;
            if ($urandom_range(3) == 0) req_a = '1;
            req_first = NREQ'($urandom) & NREQ'($urandom);
            req_last = NREQ'($urandom) & NREQ'($urandom);
            step();
        end
        rst = 1'b0;
        out_ready = 1'b1;
        drive_idle();
        for (int k = 0; k < 6; k++) step();
        check("final_idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
